// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: request/response handshake bundle for the pipelined add/subtract unit
interface addsub_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             co;
  logic             oflow;
  logic [WIDTH-1:0] acc_q;
  modport master (
    output in_valid, sub, acc, a, b, clr_acc, out_ready,
    input  in_ready, out_valid, z, co, oflow, acc_q
  );
  modport slave (
    input  in_valid, sub, acc, a, b, clr_acc, out_ready,
    output in_ready, out_valid, z, co, oflow, acc_q
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented-carry pipelined add/subtract with flags, optional saturation and accumulator
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_pipe_if.slave       bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] x_d [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] y_d [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             o_q [STAGES];
  logic             o_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             k_q [STAGES];
  logic             k_d [STAGES];
  logic             acc_pending_q, acc_pending_d;
  logic [WIDTH-1:0] acc_val_q, acc_val_d;
  logic [WIDTH-1:0] xi, yi, ri;
  logic             ci, vi, ki, of;
  logic [SW:0]      seg;
  logic             adv, take, retire;
  int               p;
  assign adv           = !v_q[L] || bus.out_ready;
  assign bus.in_ready  = adv && !acc_pending_q;
  assign take          = bus.in_valid && bus.in_ready;
  assign retire        = v_q[L] && bus.out_ready && k_q[L];
  assign bus.out_valid = v_q[L];
  assign bus.z         = r_q[L];
  assign bus.co        = c_q[L];
  assign bus.oflow     = o_q[L];
  assign bus.acc_q     = acc_val_q;
  // Each stage adds its own segment, forwarding operands, partial sum and carry to the next
  always_comb begin
    p  = 0;
    seg = '0;
    of = 1'b0;
    xi = bus.acc ? acc_val_q : bus.a;
    yi = bus.sub ? ~bus.b : bus.b;
    ri = '0;
    ci = bus.sub;
    vi = take;
    ki = bus.acc;
    for (int s = 0; s < STAGES; s++) begin
      p = (s == 0) ? 0 : s - 1;
      if (s != 0) begin
        xi = x_q[p];
        yi = y_q[p];
        ri = r_q[p];
        ci = c_q[p];
        vi = v_q[p];
        ki = k_q[p];
      end
      seg = {1'b0, xi[s*SW +: SW]} + {1'b0, yi[s*SW +: SW]} + {{SW{1'b0}}, ci};
      r_d[s] = ri;
      r_d[s][s*SW +: SW] = seg[SW-1:0];
      of = (xi[WIDTH-1] == yi[WIDTH-1]) && (r_d[s][WIDTH-1] != xi[WIDTH-1]);
      if (SAT != 0 && s == L && of)
        r_d[s] = {xi[WIDTH-1], {(WIDTH-1){~xi[WIDTH-1]}}};
      x_d[s] = xi;
      y_d[s] = yi;
      c_d[s] = seg[SW];
      o_d[s] = of;
      v_d[s] = vi;
      k_d[s] = ki;
    end
  end
  // Accumulator and pending flag: clear beats retirement; acc ops block intake until they retire
  always_comb begin
    acc_pending_d = (take && bus.acc) ? 1'b1 : retire ? 1'b0 : acc_pending_q;
    acc_val_d     = bus.clr_acc ? '0 : retire ? r_q[L] : acc_val_q;
  end
  // Pipeline registers advance together or all hold on a downstream stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        x_q[s] <= '0;
        y_q[s] <= '0;
        r_q[s] <= '0;
        c_q[s] <= 1'b0;
        o_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
        k_q[s] <= 1'b0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        x_q[s] <= x_d[s];
        y_q[s] <= y_d[s];
        r_q[s] <= r_d[s];
        c_q[s] <= c_d[s];
        o_q[s] <= o_d[s];
        v_q[s] <= v_d[s];
        k_q[s] <= k_d[s];
      end
    end
  end
  // Accumulator state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pending_q <= 1'b0;
      acc_val_q     <= '0;
    end else begin
      acc_pending_q <= acc_pending_d;
      acc_val_q     <= acc_val_d;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of an 8-bit, 2-stage unit with and without saturation
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  addsub_pipe_if #(.WIDTH(8)) if0 ();
  addsub_pipe_if #(.WIDTH(8)) if1 ();
  addsub_pipe #(.WIDTH(8), .STAGES(2), .SAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  addsub_pipe #(.WIDTH(8), .STAGES(2), .SAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  assign if1.in_valid  = if0.in_valid;
  assign if1.sub       = if0.sub;
  assign if1.acc       = if0.acc;
  assign if1.a         = if0.a;
  assign if1.b         = if0.b;
  assign if1.clr_acc   = if0.clr_acc;
  assign if1.out_ready = if0.out_ready;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run1(input logic sb, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ez, input logic eco, input logic eof, input logic [7:0] ezs);
    @(negedge clk);
    if0.in_valid = 1'b1; if0.sub = sb; if0.acc = 1'b0; if0.a = av; if0.b = bv; if0.out_ready = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 chk("latency", 32'(if0.out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("out_valid", 32'(if0.out_valid), 32'd1);
    chk("z", 32'(if0.z), 32'(ez));
    chk("co", 32'(if0.co), 32'(eco));
    chk("oflow", 32'(if0.oflow), 32'(eof));
    chk("z_sat", 32'(if1.z), 32'(ezs));
    chk("oflow_sat", 32'(if1.oflow), 32'(eof));
  endtask
  task automatic acc_step(input logic [7:0] bv, input logic clr_b, input logic clr_c,
                          input logic [7:0] ez, input logic [7:0] eacc);
    @(negedge clk);
    if0.in_valid = 1'b1; if0.acc = 1'b1; if0.sub = 1'b0; if0.a = 8'h55; if0.b = bv; if0.out_ready = 1'b1;
    #1 chk("acc_rdy_idle", 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    if0.in_valid = 1'b0; if0.acc = 1'b0; if0.clr_acc = clr_b;
    #1 chk("acc_rdy_pend", 32'(if0.in_ready), 32'd0);
    @(negedge clk);
    if0.clr_acc = clr_c;
    #1;
    chk("acc_ov", 32'(if0.out_valid), 32'd1);
    chk("acc_z", 32'(if0.z), 32'(ez));
    chk("acc_rdy_ret", 32'(if0.in_ready), 32'd0);
    if (clr_b) chk("acc_clr_pend", 32'(if0.acc_q), 32'd0);
    @(negedge clk);
    if0.clr_acc = 1'b0;
    #1;
    chk("acc_q", 32'(if0.acc_q), 32'(eacc));
    chk("acc_q_sat", 32'(if1.acc_q), 32'(eacc));
    chk("acc_rdy_after", 32'(if0.in_ready), 32'd1);
  endtask
  logic [7:0] sa [4] = '{8'd10, 8'd200, 8'h7F, 8'hF0};
  logic [7:0] sbv [4] = '{8'd20, 8'd100, 8'h01, 8'h0F};
  logic [7:0] sz [4] = '{8'd30, 8'h2C, 8'h80, 8'hFF};
  initial begin
    int sent, rcvd;
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.sub = 1'b0; if0.acc = 1'b0; if0.a = '0; if0.b = '0;
    if0.clr_acc = 1'b0; if0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ov", 32'(if0.out_valid), 32'd0);
    chk("rst_z", 32'(if0.z), 32'd0);
    chk("rst_flags", {30'd0, if0.co, if0.oflow}, 32'd0);
    chk("rst_acc", 32'(if0.acc_q), 32'd0);
    chk("rst_rdy", 32'(if0.in_ready), 32'd1);
    run1(1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 8'd127);
    run1(1'b0, 8'd100, 8'd28, 8'h80, 1'b0, 1'b1, 8'h7F);
    run1(1'b1, 8'd5,   8'd7,  8'hFE, 1'b0, 1'b0, 8'hFE);
    run1(1'b1, 8'h80,  8'd1,  8'h7F, 1'b1, 1'b1, 8'h80);
    run1(1'b0, 8'hFF,  8'h01, 8'h00, 1'b1, 1'b0, 8'h00);
    run1(1'b0, 8'h0F,  8'h01, 8'h10, 1'b0, 1'b0, 8'h10);
    run1(1'b1, 8'd9,   8'd9,  8'h00, 1'b1, 1'b0, 8'h00);
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if0.out_ready = !(cyc >= 3 && cyc < 6);
      if0.in_valid = (sent < 4);
      if0.sub = 1'b0; if0.acc = 1'b0;
      if0.a = sa[sent < 4 ? sent : 0];
      if0.b = sbv[sent < 4 ? sent : 0];
      #1;
      if (if0.out_valid && !if0.out_ready) begin
        chk("stall_rdy", 32'(if0.in_ready), 32'd0);
        chk("stall_z", 32'(if0.z), 32'(sz[1]));
      end
      if (if0.out_valid && if0.out_ready) begin
        if (rcvd < 4) chk("stream_z", 32'(if0.z), 32'(sz[rcvd]));
        rcvd++;
      end
      if (if0.in_valid && if0.in_ready) sent++;
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    chk("stream_cnt", 32'(rcvd), 32'd4);
    chk("stream_sent", 32'(sent), 32'd4);
    acc_step(8'd10, 1'b0, 1'b0, 8'd10, 8'd10);
    acc_step(8'd10, 1'b0, 1'b0, 8'd20, 8'd20);
    acc_step(8'd10, 1'b0, 1'b0, 8'd30, 8'd30);
    acc_step(8'd5,  1'b1, 1'b0, 8'd35, 8'd35);
    @(negedge clk);
    if0.clr_acc = 1'b1;
    @(negedge clk);
    if0.clr_acc = 1'b0;
    #1 chk("clr_acc", 32'(if0.acc_q), 32'd0);
    acc_step(8'd10, 1'b0, 1'b1, 8'd10, 8'd0);
    acc_step(8'd9,  1'b0, 1'b0, 8'd9,  8'd9);
    @(negedge clk);
    if0.in_valid = 1'b1; if0.acc = 1'b0; if0.sub = 1'b0; if0.a = 8'd1; if0.b = 8'd2; if0.out_ready = 1'b0;
    @(negedge clk);
    if0.a = 8'd3; if0.b = 8'd4;
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 chk("pre_rst_ov", 32'(if0.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(if0.out_valid), 32'd0);
    chk("arst_z", 32'(if0.z), 32'd0);
    chk("arst_acc", 32'(if0.acc_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("post_rst_ov", 32'(if0.out_valid), 32'd0);
    end
    run1(1'b0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0, 8'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshakes, carry/overflow flags, optional signed saturation and an internal accumulate mode. The carry chain is split into STAGES registered segments so wide operands meet timing. It serves as the arithmetic engine for pointer, occupancy and level calculations in the FIFO datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, number of pipeline segments/register stages, 1..WIDTH; equals latency in cycles.
SAT, 0, 1 = on signed overflow, z saturates to max/min instead of wrapping.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operation request.
in_ready  out  1  unit accepts the request this cycle.
sub  in  1  0 = a+b, 1 = a-b.
acc  in  1  1 = operand A is acc_q; a is ignored.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
clr_acc  in  1  synchronous clear of acc_q.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
z  out  WIDTH  result.
co  out  1  carry out of MSB (for subtract: 1 = no borrow).
oflow  out  1  signed overflow (carry into MSB XOR carry out of MSB).
acc_q  out  WIDTH  accumulator value.

Behaviour:
- Reset (async, rst_n=0): all stage valids, out_valid, z, co, oflow, acc_q and acc_pending cleared to 0 immediately; in-flight operations discarded.
- Arithmetic: z = A + (sub ? ~b : b) + sub, modulo 2^WIDTH; carry into segment 0 = sub; each segment of WIDTH/STAGES bits ripples its carry into the next stage's register.
- SAT=1 and oflow=1: z = A[MSB] ? 100..0 : 011..1; oflow and co are still reported unmodified.
- Advance: pipe moves iff (!out_valid || out_ready); otherwise every stage holds, and z/co/oflow stay stable while out_valid && !out_ready. Bubbles are not collapsed.
- Accept: transfer occurs when in_valid && in_ready. in_ready = advance && !acc_pending.
- Latency: STAGES edges. The accepting edge counts as edge 1; out_valid rises after edge STAGES. Throughput is 1 op/cycle when no stall and no accumulate.
- Accumulate: accepting an acc=1 op sets acc_pending, and in_ready is 0 until that op retires. At retirement (out_valid && out_ready for that op), acc_q <= z (saturated value if SAT) and acc_pending clears. acc=1 ops therefore never read a stale acc_q.
- clr_acc: acc_q <= 0 on the next edge. If it coincides with an accumulate retirement, the clear wins. A clear during acc_pending does not cancel the pending op; its later retirement writes z.
- acc_q changes only through reset, clr_acc or accumulate retirement. Non-acc ops never touch it.
- Operand/control inputs are don't-care when in_valid=0. Outputs are X-free after reset.

Test Plan:
1. WIDTH=8, STAGES=2, SAT=0: accept add 100+27 at edge k -> out_valid after edge k+1, z=127, co=0, oflow=0.
2. Add 100+28 -> z=0x80, co=0, oflow=1. With SAT=1 -> z=0x7F, oflow=1.
3. Sub 5-7 -> z=0xFE, co=0, oflow=0. Sub 0x80-1 -> z=0x7F, co=1, oflow=1 (SAT=1: z=0x80).
4. Stream of 4 back-to-back adds with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, z held stable, all 4 results delivered in order with none lost or duplicated.
5. acc=1, b=10, sub=0, issued 3 times -> acc_q 10, 20, 30; in_ready=0 from each acceptance until its retirement. Then clr_acc -> acc_q=0. clr_acc coincident with a retirement -> acc_q=0.
6. rst_n pulsed low with 2 ops in flight -> out_valid/z/acc_q 0 immediately; no result emitted after release; next op completes normally.
